calc_op_encoder: RTL
====================

# calc_op_encoder

Registered, debounced successor to the combinational calculator button encoder. It synchronises and debounces the board push-buttons, and captures one 4-bit ALU opcode per press of the enter button (btnd). It presents the opcode to the calculator datapath over a valid/ready handshake. It sits between the board button pins and the accumulator/ALU stage of the calculator top level.

## Interface
- DEB_CYCLES, default 16: consecutive stable cycles required before a debounced level changes; legal range ≥ 1.
- SYNC_STAGES, default 2: synchroniser flops per button input; legal range ≥ 2.
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous and active-high.
- btnl  input  1  raw left button, opcode select bit l.
- btnc  input  1  raw centre button, opcode select bit c.
- btnr  input  1  raw right button, opcode select bit r.
- btnd  input  1  raw enter button; a debounced press captures an opcode.
- btnu  input  1  raw bank button; used only with CALC_ENC_BANK_EN, otherwise ignored.
- op_ready  input  1  downstream accepts the opcode when high together with op_valid.
- alu_op  output  4  captured opcode; stable while op_valid is high.
- op_valid  output  1  opcode available.
- bank  output  1  current opcode bank; constant 0 without CALC_ENC_BANK_EN.

## Operation
- **Input conditioning.** Each of btnl, btnc, btnr, btnd and btnu passes through SYNC_STAGES flops, then through its own debouncer.
- **Debouncer.** A counter of width $clog2(DEB_CYCLES+1).
  - The counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments; on the edge where it would reach DEB_CYCLES, the debounced level flips and the counter clears.
- **Bank 0 encoding** (debounced {l,c,r} → alu_op): 000→0000, 001→0001, 010→0010, 011→0110, 100→0100, 101→1001, 110→1010, 111→0101.
- **Bank 1 encoding:** alu_op = {1'b1, l, c, r}.
- **FSM states:** IDLE, PEND, HOLD.
  - IDLE: when debounced btnd = 1, latch the encoding of the current debounced {l,c,r} and bank into alu_op, set op_valid, go to PEND.
  - PEND: op_valid = 1 and alu_op held. When op_ready = 1, clear op_valid. Next state is HOLD if debounced btnd = 1, else IDLE.
  - HOLD: wait for debounced btnd = 0, then go to IDLE. Exactly one opcode is issued per press, whatever the hold duration.
- **Changes while PEND:** select-button changes and further enter activity do not alter alu_op.
- **Reset behaviour:**
  - On rst, all sync flops, debounced levels, counters and bank go to 0, state goes to IDLE, and alu_op = 0000, op_valid = 0.
  - rst mid-handshake drops op_valid at that edge; no opcode is retained.
  - An enter held through reset produces one capture once its debounced level rises.

## Timing
- **Raw edge to debounced level.** A raw change sampled at edge k and held stable appears at the synchroniser output after edge k+SYNC_STAGES−1. The debounced level changes at edge k+SYNC_STAGES−1+DEB_CYCLES.
- **Debounced enter to op_valid.** op_valid rises at the edge after debounced btnd rises, i.e. 1 cycle of FSM latency.
- **Handshake transfer.** A transfer occurs on an edge where op_valid && op_ready. op_valid is low in the following cycle.
- **op_ready held high in IDLE.** op_valid is high for exactly 1 cycle.
- **Glitches.** A raw pulse shorter than DEB_CYCLES cycles after synchronisation never changes a debounced level.

## Configuration
- **Macro CALC_ENC_BANK_EN.**
- **Defined:** each rising edge of debounced btnu toggles bank, in any FSM state.
  - A toggle affects only captures made after it.
  - bank and a capture on the same edge: the capture uses the pre-toggle bank.
- **Undefined:**
  - btnu is ignored, with no sync or debounce logic for it.
  - bank is tied to 0 and only the bank-0 encoding exists.

## Test plan
All scenarios use DEB_CYCLES = 4, SYNC_STAGES = 2.

- **Reset values:** rst high for 3 cycles with all buttons high → alu_op = 0000, op_valid = 0, bank = 0 during reset. After release, exactly one capture alu_op = 0101 occurs, with op_valid rising 6 cycles after rst falls.
- **Full bank-0 table:** all 8 {l,c,r} combinations, each followed by an enter press with op_ready = 1 → alu_op sequence 0000, 0001, 0010, 0110, 0100, 1001, 1010, 0101, each with a 1-cycle op_valid.
- **Glitch rejection:** a 3-cycle btnd pulse → no op_valid. A 10-cycle pulse → one op_valid, rising 6 cycles after the raw rise.
- **Backpressure:** op_ready = 0 for 20 cycles after capture of 1001, while btnl/btnc/btnr toggle → op_valid and alu_op = 1001 are held; the transfer happens on the first op_ready = 1 edge.
- **Long hold:** enter held for 200 cycles with op_ready = 1 → exactly one op_valid pulse. A second press after release gives a second pulse.
- **Bank mode (CALC_ENC_BANK_EN):** btnu pressed once, then {l,c,r} = 011 and enter → bank = 1, alu_op = 1011. Pressing btnu again, then enter → bank = 0, alu_op = 0110.

Source files
------------

// File: rtl/calc_op_encoder.sv
// calc_op_encoder
//   Synchronises and debounces the calculator push-buttons and captures one
//   4-bit ALU opcode per debounced press of the enter button (btnd). The
//   opcode is offered downstream on a valid/ready handshake.
//
//   Optional feature macro: CALC_ENC_BANK_EN
//     defined   : debounced rising edges of btnu toggle the opcode bank.
//                 Bank 1 opcodes are {1, l, c, r}.
//     undefined : btnu is ignored, bank is tied to 0.
//
//   Parameters
//     DEB_CYCLES  (>=1) stable cycles before a debounced level changes
//     SYNC_STAGES (>=2) synchroniser flops per button
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     btnl, btnc, btnr     raw opcode select buttons
//     btnd                 raw enter button
//     btnu                 raw bank button (bank feature only)
//     op_ready             downstream accepts the opcode
//     alu_op               captured opcode, stable while op_valid
//     op_valid             opcode available
//     bank                 current opcode bank
module calc_op_encoder #(
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnl,
    input  logic       btnc,
    input  logic       btnr,
    input  logic       btnd,
    input  logic       btnu,
    input  logic       op_ready,
    output logic [3:0] alu_op,
    output logic       op_valid,
    output logic       bank
);

`ifdef CALC_ENC_BANK_EN
    localparam int unsigned NBTN = 5;
`else
    localparam int unsigned NBTN = 4;
`endif

    localparam int unsigned B_L = 0;
    localparam int unsigned B_C = 1;
    localparam int unsigned B_R = 2;
    localparam int unsigned B_D = 3;

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        HOLD
    } state_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync_q [SYNC_STAGES];
    logic [NBTN-1:0] btn_sync;
    logic [NBTN-1:0] deb_q;
    logic [CW-1:0]   deb_cnt [NBTN];

    state_t     state_q;
    state_t     state_d;
    logic       capture;
    logic [3:0] alu_op_q;
    logic       bank_cur;

`ifdef CALC_ENC_BANK_EN
    localparam int unsigned B_U = 4;
    assign btn_raw = {btnu, btnd, btnr, btnc, btnl};
`else
    logic unused_btnu;
    assign unused_btnu = btnu;
    assign btn_raw     = {btnd, btnr, btnc, btnl};
`endif

    // Synchroniser chain: stage 0 samples the raw pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= btn_raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Debouncer: any agreement with the current level restarts the count;
    // the level flips on the edge the count would reach DEB_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= '0;
            for (int unsigned b = 0; b < NBTN; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NBTN; b++) begin
                if (btn_sync[b] == deb_q[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == CNT_LAST) begin
                    deb_q[b]   <= btn_sync[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + CW'(1);
                end
            end
        end
    end

`ifdef CALC_ENC_BANK_EN
    logic bank_q;
    logic bank_toggle;

    // Toggle on the same edge the debounced btnu rises; a capture on that
    // edge still reads the old bank_q.
    assign bank_toggle = ~deb_q[B_U] & btn_sync[B_U] & (deb_cnt[B_U] == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= 1'b0;
        end else if (bank_toggle) begin
            bank_q <= ~bank_q;
        end
    end

    assign bank_cur = bank_q;
`else
    assign bank_cur = 1'b0;
`endif

    function automatic logic [3:0] encode(input logic bank_sel, input logic [2:0] lcr);
        logic [3:0] op;
        if (bank_sel) begin
            op = {1'b1, lcr};
        end else begin
            case (lcr)
                3'b000:  op = 4'b0000;
                3'b001:  op = 4'b0001;
                3'b010:  op = 4'b0010;
                3'b011:  op = 4'b0110;
                3'b100:  op = 4'b0100;
                3'b101:  op = 4'b1001;
                3'b110:  op = 4'b1010;
                default: op = 4'b0101;
            endcase
        end
        return op;
    endfunction

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (deb_q[B_D]) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (op_ready) begin
                    state_d = deb_q[B_D] ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!deb_q[B_D]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            alu_op_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                alu_op_q <= encode(bank_cur, {deb_q[B_L], deb_q[B_C], deb_q[B_R]});
            end
        end
    end

    assign alu_op   = alu_op_q;
    assign op_valid = (state_q == PEND);
    assign bank     = bank_cur;

endmodule
